// File: rtl/dll_ack_gen.sv
// Data-link ACK/NAK generator: parses header/payload/trailer TLPs, checks the XOR
// trailer and sequence number, and releases payload downstream only once acknowledged.
module dll_ack_gen #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tlp_data,
  input  logic        tlp_valid,
  output logic        tlp_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        ack,
  output logic        nack,
  output logic [11:0] ack_seq
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  typedef enum logic [1:0] {S_HDR, S_PAY, S_TRL} state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   wr_spec_reg;
  logic [PTR_W-1:0]   wr_commit_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [11:0]        exp_seq_reg;
  logic [11:0]        seq_reg;
  logic [11:0]        ack_seq_reg;
  logic [7:0]         len_reg;
  logic [7:0]         cnt_reg;
  logic [31:0]        check_reg;
  logic               malformed_reg;
  logic               ack_reg;
  logic               nack_reg;
  logic               out_valid_reg;
  logic [32:0]        rd_word_reg;
  logic [32:0]        mem [DEPTH];

  logic [PTR_W-1:0]   used;
  logic               full;
  logic               accept;
  logic [7:0]         hdr_len;
  logic               hdr_malformed;
  logic               wr_en;
  logic               last_word;
  logic               avail;
  logic               load;
  logic               good;
  logic               seq_new;
  logic               seq_dup;

  // Occupancy includes uncommitted words and the word parked in the output register.
  assign used          = wr_spec_reg - rd_ptr_reg + PTR_W'(out_valid_reg);
  assign full          = (used == PTR_W'(DEPTH));
  assign tlp_ready     = !rst && ((state_reg != S_PAY) || malformed_reg || !full);
  assign accept        = tlp_valid && tlp_ready;
  assign hdr_len       = tlp_data[7:0];
  assign hdr_malformed = (hdr_len == 8'd0) || ({24'd0, hdr_len} > 32'(DEPTH));
  assign wr_en         = accept && (state_reg == S_PAY) && !malformed_reg;
  assign last_word     = (cnt_reg == (len_reg - 8'd1));
  assign avail         = (rd_ptr_reg != wr_commit_reg);
  assign load          = avail && (!out_valid_reg || out_ready);
  assign good          = (tlp_data == check_reg) && !malformed_reg;
  assign seq_new       = (seq_reg == exp_seq_reg);
  assign seq_dup       = (seq_reg == (exp_seq_reg - 12'd1));

  assign out_data  = rd_word_reg[31:0];
  assign out_last  = rd_word_reg[32] && out_valid_reg;
  assign out_valid = out_valid_reg;
  assign ack       = ack_reg;
  assign nack      = nack_reg;
  assign ack_seq   = ack_seq_reg;

  // Payload store; read address only ever trails the commit pointer, so it never
  // collides with the speculative write slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_spec_reg[AW-1:0]] <= {last_word, tlp_data};
    end
    if (load) begin
      rd_word_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_HDR;
      wr_spec_reg   <= '0;
      wr_commit_reg <= '0;
      rd_ptr_reg    <= '0;
      exp_seq_reg   <= '0;
      seq_reg       <= '0;
      ack_seq_reg   <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      check_reg     <= '0;
      malformed_reg <= 1'b0;
      ack_reg       <= 1'b0;
      nack_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      ack_reg  <= 1'b0;
      nack_reg <= 1'b0;

      if (load) begin
        rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      if (wr_en) begin
        wr_spec_reg <= wr_spec_reg + PTR_W'(1);
      end

      case (state_reg)
        S_HDR: begin
          if (accept) begin
            seq_reg       <= tlp_data[31:20];
            len_reg       <= hdr_len;
            cnt_reg       <= '0;
            check_reg     <= tlp_data;
            malformed_reg <= hdr_malformed;
            state_reg     <= (hdr_len == 8'd0) ? S_TRL : S_PAY;
          end
        end
        S_PAY: begin
          if (accept) begin
            check_reg <= check_reg ^ tlp_data;
            cnt_reg   <= cnt_reg + 8'd1;
            if (last_word) begin
              state_reg <= S_TRL;
            end
          end
        end
        S_TRL: begin
          if (accept) begin
            state_reg <= S_HDR;
            if (good && seq_new) begin
              ack_reg       <= 1'b1;
              ack_seq_reg   <= seq_reg;
              wr_commit_reg <= wr_spec_reg;
              exp_seq_reg   <= exp_seq_reg + 12'd1;
            end else if (good && seq_dup) begin
              ack_reg     <= 1'b1;
              ack_seq_reg <= seq_reg;
              wr_spec_reg <= wr_commit_reg;
            end else begin
              nack_reg    <= 1'b1;
              ack_seq_reg <= exp_seq_reg - 12'd1;
              wr_spec_reg <= wr_commit_reg;
            end
          end
        end
        default: state_reg <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_dll_ack_gen.sv
// Self-checking bench for dll_ack_gen: directed scenarios plus randomized TLPs
// compared against a transaction-level model of the acknowledge rules.
module tb_dll_ack_gen;

  localparam int DEPTH = 16;

  typedef logic [31:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tlp_data = '0;
  logic        tlp_valid = 1'b0;
  logic        tlp_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        ack;
  logic        nack;
  logic [11:0] ack_seq;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [32:0] exp_out[$];
  int          exp_seq = 0;
  bit          resp_pending = 0;
  bit          exp_ack = 0;
  logic [11:0] exp_ack_seq = '0;
  bit          rand_ready = 0;

  dll_ack_gen #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .tlp_data  (tlp_data),
    .tlp_valid (tlp_valid),
    .tlp_ready (tlp_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .ack       (ack),
    .nack      (nack),
    .ack_seq   (ack_seq)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic abort_timeout(input string tag);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got timeout expected handshake", tag);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  endtask

  // Response and output-stream monitor.
  always @(negedge clk) begin
    if (resp_pending) begin
      chk("ack", ack, exp_ack);
      chk("nack", nack, !exp_ack);
      chk("ack_seq", ack_seq, exp_ack_seq);
      chk("ready_in_ack_cycle", tlp_ready, 1);
      $display("[TB] resp %s seq=%03h", ack ? "ack" : "nak", ack_seq);
      resp_pending = 0;
    end else if (ack || nack) begin
      chk("unexpected_resp", {ack, nack}, 2'b00);
    end
    if (out_valid && out_ready) begin
      if (exp_out.size() == 0) begin
        tests_run++;
        assert (exp_out.size() != 0) else begin
          tests_failed++;
          $error("FAIL spurious_out: got %0h expected no word", {out_last, out_data});
        end
      end else begin
        chk("out_word", {out_last, out_data}, exp_out.pop_front());
      end
    end
  end

  function automatic wq_t rand_pl(input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back($urandom);
    return q;
  endfunction

  // Tasks start and end 1 time unit after a rising edge.
  task automatic send_word(input logic [31:0] d, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        tlp_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    tlp_valid = 1'b1;
    tlp_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (tlp_ready) break;
      n++;
      if (n > 500) abort_timeout("tlp_handshake");
    end
    @(posedge clk);
    #1;
    tlp_valid = 1'b0;
  endtask

  task automatic send_tlp(input logic [11:0] seq, input logic [7:0] len, input wq_t pl,
                          input bit corrupt, input bit gaps);
    logic [31:0] hdr;
    logic [31:0] x;
    bit          well;
    hdr = {seq, 12'($urandom), len};
    x = hdr;
    send_word(hdr, gaps);
    for (int i = 0; i < int'(len); i++) begin
      x ^= pl[i];
      send_word(pl[i], gaps);
    end
    send_word(corrupt ? (x ^ 32'h1) : x, gaps);
    well = (len != 0) && (int'(len) <= DEPTH);
    if (!corrupt && well && int'(seq) == exp_seq) begin
      exp_ack = 1;
      exp_ack_seq = seq;
      for (int i = 0; i < int'(len); i++) exp_out.push_back({(i == int'(len) - 1), pl[i]});
      exp_seq = (exp_seq + 1) % 4096;
    end else if (!corrupt && well && int'(seq) == (exp_seq + 4095) % 4096) begin
      exp_ack = 1;
      exp_ack_seq = seq;
    end else begin
      exp_ack = 0;
      exp_ack_seq = 12'((exp_seq + 4095) % 4096);
    end
    resp_pending = 1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tlp_valid = 1'b0;
    @(posedge clk);
    #1;
    resp_pending = 0;
    exp_out.delete();
    exp_seq = 0;
    @(negedge clk);
    chk("rst_tlp_ready", tlp_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_ack_nack", {ack, nack}, 2'b00);
    chk("rst_ack_seq", ack_seq, 12'h000);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_out.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_remaining", exp_out.size(), 0);
    chk("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    wq_t pl;
    int  k;
    int  len;
    logic [11:0] s;

    reset_dut();
    out_ready = 1'b1;

    // Bad CRC from reset: nak of 0xFFF, nothing forwarded.
    send_tlp(12'h000, 8'd2, rand_pl(2), 1, 0);
    repeat (4) begin
      @(negedge clk);
      chk("badcrc_no_out", out_valid, 0);
      @(posedge clk);
      #1;
    end

    // Good TLP with payload A, B, C.
    pl = {32'hA, 32'hB, 32'hC};
    send_tlp(12'h000, 8'd3, pl, 0, 0);
    drain();

    // Duplicate of the same TLP: ack again, no new output.
    send_tlp(12'h000, 8'd3, pl, 0, 0);
    drain();

    // Bad CRC now reports expected_seq-1 = 0; then a malformed len==0 TLP.
    send_tlp(12'h001, 8'd1, rand_pl(1), 1, 0);
    send_tlp(12'h001, 8'd0, rand_pl(0), 0, 0);
    send_tlp(12'h001, 8'd20, rand_pl(20), 0, 1);
    drain();

    // Full buffer backpressure.
    reset_dut();
    out_ready = 1'b0;
    send_tlp(12'h000, 8'd16, rand_pl(16), 0, 0);
    fork
      send_tlp(12'h001, 8'd4, rand_pl(4), 0, 0);
      begin
        repeat (6) @(negedge clk);
        chk("full_block", tlp_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("full_after_3_pops", tlp_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized TLP mix under random downstream backpressure.
    rand_ready = 1;
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 6);
      case (k)
        0, 1, 2: begin
          len = $urandom_range(1, DEPTH);
          send_tlp(12'(exp_seq), 8'(len), rand_pl(len), 0, 1);
        end
        3: begin
          len = $urandom_range(1, DEPTH);
          send_tlp(12'((exp_seq + 4095) % 4096), 8'(len), rand_pl(len), 0, 1);
        end
        4: begin
          len = $urandom_range(1, DEPTH);
          send_tlp(12'(exp_seq), 8'(len), rand_pl(len), 1, 1);
        end
        5: begin
          len = $urandom_range(1, DEPTH);
          s = 12'((exp_seq + 2 + $urandom_range(0, 100)) % 4096);
          send_tlp(s, 8'(len), rand_pl(len), 0, 1);
        end
        default: begin
          len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(DEPTH + 1, 40);
          send_tlp(12'(exp_seq), 8'(len), rand_pl(len), 0, 1);
        end
      endcase
    end
    rand_ready = 0;
    #1;
    out_ready = 1'b1;
    drain();

    // Advance to sequence 4095, then wrap to 0.
    while (exp_seq != 4095) begin
      send_tlp(12'(exp_seq), 8'd1, rand_pl(1), 0, 0);
    end
    send_tlp(12'hFFF, 8'd2, rand_pl(2), 0, 0);
    send_tlp(12'h000, 8'd1, rand_pl(1), 0, 0);
    send_tlp(12'h000, 8'd1, rand_pl(1), 1, 0);
    drain();

    // Reset in the middle of a TLP.
    send_word({12'h001, 12'h0, 8'd5}, 0);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    reset_dut();
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_out", out_valid, 0);
      @(posedge clk);
      #1;
    end
    send_tlp(12'h000, 8'd2, rand_pl(2), 0, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
